gf180mcu_fd_sc_mcu9t5v0__rowpwr_seq: RTL and testbench

GF180MCU_FD_SC_MCU9T5V0__ROWPWR_SEQ -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__rowpwr_seq

---
 rtl/gf180mcu_fd_sc_mcu9t5v0__rowpwr_seq.sv | 164 ++++++++++++++++
 tb/tb_gf180mcu_fd_sc_mcu9t5v0__rowpwr_seq.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rowpwr_seq.sv
// Row power-switch sequencer: ramps thermometer-coded row enables up and down with a
// settle gap per row, and watches the far-end power-good return for faults.
module gf180mcu_fd_sc_mcu9t5v0__rowpwr_seq #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 64
) (
`ifdef USE_POWER_PINS
  inout  wire             VDD,
  inout  wire             VSS,
`endif
  input  logic            CLK,
  input  logic            RST,
  input  logic            REQ,
  input  logic            ACK,
  output logic [ROWS-1:0] EN,
  output logic            RDY,
  output logic            ERR
);

  // Counters are sized for the largest legal SETTLE (255) and TIMEOUT (65535).
  localparam logic [7:0]  StepLast = 8'(SETTLE - 1);
  localparam logic [15:0] TmoLast  = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StOff,
    StRamp,
    StWaitAck,
    StOn,
    StDown,
    StFault
  } state_e;

  state_e          state_q, state_d;
  logic [ROWS-1:0] en_q, en_d;
  logic [7:0]      step_q, step_d;
  logic [15:0]     tmo_q, tmo_d;
  logic            rdy_q, rdy_d;
  logic            err_q, err_d;
  logic            ack_meta_q, ack_s_q;
  logic            step_done;

  // ACK comes from the far endcap with no timing relationship to CLK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= ACK;
      ack_s_q    <= ack_meta_q;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StOff;
      en_q    <= '0;
      step_q  <= '0;
      tmo_q   <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      step_q  <= step_d;
      tmo_q   <= tmo_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign step_done = (step_q == StepLast);

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    step_d  = step_q;
    tmo_d   = tmo_q;

    unique case (state_q)
      StOff: begin
        if (REQ) begin
          state_d = StRamp;
          en_d    = '0;
          en_d[0] = 1'b1;
          step_d  = '0;
        end
      end

      StRamp: begin
        if (!REQ) begin
          state_d = StDown;
          step_d  = '0;
        end else if (step_done) begin
          step_d = '0;
          en_d   = {en_q[ROWS-2:0], 1'b1};
          // Top row is the one being switched on now.
          if (en_q[ROWS-2]) begin
            state_d = StWaitAck;
            tmo_d   = '0;
          end
        end else begin
          step_d = step_q + 8'd1;
        end
      end

      StWaitAck: begin
        // Timeout wins over a simultaneous power-down request.
        if (!ack_s_q && (tmo_q == TmoLast)) begin
          state_d = StFault;
          en_d    = '0;
        end else if (!REQ) begin
          state_d = StDown;
          step_d  = '0;
        end else if (ack_s_q) begin
          state_d = StOn;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      StOn: begin
        if (!ack_s_q) begin
          state_d = StFault;
          en_d    = '0;
        end else if (!REQ) begin
          state_d = StDown;
          step_d  = '0;
        end
      end

      StDown: begin
        if (step_done) begin
          step_d = '0;
          en_d   = en_q >> 1;
          if (!en_q[1]) begin
            state_d = StOff;
          end
        end else begin
          step_d = step_q + 8'd1;
        end
      end

      StFault: begin
        if (!REQ) begin
          state_d = StOff;
        end
      end

      default: begin
        state_d = StOff;
        en_d    = '0;
      end
    endcase

    rdy_d = (state_d == StOn);
    err_d = (state_d == StFault);
  end

  assign EN  = en_q;
  assign RDY = rdy_q;
  assign ERR = err_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rowpwr_seq.sv
// Directed bench for the row power sequencer at ROWS=4, SETTLE=2, TIMEOUT=8.
module tb_gf180mcu_fd_sc_mcu9t5v0__rowpwr_seq;

  logic       clk;
  logic       rst;
  logic       req;
  logic       ack;
  logic [3:0] en;
  logic       rdy;
  logic       err;

  int n_total = 0;
  int n_bad   = 0;

  gf180mcu_fd_sc_mcu9t5v0__rowpwr_seq #(
    .ROWS   (4),
    .SETTLE (2),
    .TIMEOUT(8)
  ) u_dut (
`ifdef USE_POWER_PINS
    .VDD(),
    .VSS(),
`endif
    .CLK(clk),
    .RST(rst),
    .REQ(req),
    .ACK(ack),
    .EN (en),
    .RDY(rdy),
    .ERR(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then step off the edge before sampling.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;
    ack = 1'b1;
    #12;
    check_eq("rst_en", 32'(en), 32'h0);
    check_eq("rst_rdy", 32'(rdy), 32'h0);
    check_eq("rst_err", 32'(err), 32'h0);
    rst = 1'b0;
    edges(3);
    check_eq("idle_en", 32'(en), 32'h0);

    // Power-up with ACK held high; this edge is e0.
    req = 1'b1;
    edges(1);
    check_eq("up_e1", 32'(en), 32'h1);
    edges(1);
    check_eq("up_e2", 32'(en), 32'h1);
    edges(1);
    check_eq("up_e3", 32'(en), 32'h3);
    edges(2);
    check_eq("up_e5", 32'(en), 32'h7);
    edges(2);
    check_eq("up_e7", 32'(en), 32'hF);
    check_eq("up_e7_rdy", 32'(rdy), 32'h0);
    edges(1);
    check_eq("up_e8_rdy", 32'(rdy), 32'h1);
    check_eq("up_e8_en", 32'(en), 32'hF);

    // Power-down from ON.
    req = 1'b0;
    edges(1);
    check_eq("dn_d1_rdy", 32'(rdy), 32'h0);
    check_eq("dn_d1_en", 32'(en), 32'hF);
    edges(2);
    check_eq("dn_d3", 32'(en), 32'h7);
    edges(2);
    check_eq("dn_d5", 32'(en), 32'h3);
    edges(2);
    check_eq("dn_d7", 32'(en), 32'h1);
    edges(1);
    check_eq("dn_d8", 32'(en), 32'h1);
    edges(1);
    check_eq("dn_d9", 32'(en), 32'h0);
    edges(1);
    check_eq("dn_off", 32'(en), 32'h0);

    // Timeout with ACK low.
    ack = 1'b0;
    edges(3);
    req = 1'b1;
    edges(1);
    check_eq("to_t1", 32'(en), 32'h1);
    edges(6);
    check_eq("to_t7", 32'(en), 32'hF);
    edges(7);
    check_eq("to_t14_err", 32'(err), 32'h0);
    check_eq("to_t14_en", 32'(en), 32'hF);
    edges(1);
    check_eq("to_t15_err", 32'(err), 32'h1);
    check_eq("to_t15_en", 32'(en), 32'h0);
    edges(1);
    check_eq("to_hold_err", 32'(err), 32'h1);
    req = 1'b0;
    edges(1);
    check_eq("to_off_err", 32'(err), 32'h0);
    check_eq("to_off_en", 32'(en), 32'h0);

    // Lost ACK while ON.
    ack = 1'b1;
    edges(3);
    req = 1'b1;
    edges(8);
    check_eq("la_on_rdy", 32'(rdy), 32'h1);
    ack = 1'b0;
    edges(1);
    check_eq("la_a1_err", 32'(err), 32'h0);
    edges(1);
    check_eq("la_a2_err", 32'(err), 32'h0);
    check_eq("la_a2_rdy", 32'(rdy), 32'h1);
    edges(1);
    check_eq("la_a3_err", 32'(err), 32'h1);
    check_eq("la_a3_en", 32'(en), 32'h0);
    check_eq("la_a3_rdy", 32'(rdy), 32'h0);
    req = 1'b0;
    ack = 1'b1;
    edges(1);
    check_eq("la_off_err", 32'(err), 32'h0);

    // Abort mid-ramp, re-request during DOWN.
    edges(3);
    req = 1'b1;
    edges(1);
    check_eq("ab_r1", 32'(en), 32'h1);
    edges(2);
    check_eq("ab_r3", 32'(en), 32'h3);
    req = 1'b0;
    edges(1);
    check_eq("ab_r4", 32'(en), 32'h3);
    req = 1'b1;
    edges(1);
    check_eq("ab_r5", 32'(en), 32'h3);
    edges(1);
    check_eq("ab_r6", 32'(en), 32'h1);
    edges(1);
    check_eq("ab_r7", 32'(en), 32'h1);
    edges(1);
    check_eq("ab_r8", 32'(en), 32'h0);
    edges(1);
    check_eq("ab_r9", 32'(en), 32'h1);
    edges(2);
    check_eq("ab_r11", 32'(en), 32'h3);
    edges(2);
    check_eq("ab_r13", 32'(en), 32'h7);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_en", 32'(en), 32'h0);
    check_eq("ar_rdy", 32'(rdy), 32'h0);
    check_eq("ar_err", 32'(err), 32'h0);
    #1;
    rst = 1'b0;
    edges(1);
    check_eq("ar_restart", 32'(en), 32'h1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
